wbu: RTL and testbench

Write-back unit at the far end of the MEM/WB pipeline register: consumes the registered MEM/WB payload, selects the rd write data, owns and writes the 32×64 integer register file, and issues CSR writes. It provides combinational register reads with write-through bypass to the decode stage, a registered commit trace, and a retired-instruction counter. An ebreak halt FSM freezes architectural state after an `ebreak` commits.

---
 rtl/wbu_if.sv | 37 +++
 rtl/wbu.sv | 153 +++++++++++++++
 tb/tb_wbu.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbu_if.sv
// MEM/WB payload bundle presented to the write-back unit.
// The master drives the registered payload; the WBU answers with in_ready.
interface wbu_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_pc;
    logic [31:0]     in_inst;
    logic [4:0]      in_rd;
    logic            in_rd_w_en;
    logic            in_rd_w_src_exu;
    logic            in_rd_w_src_mem;
    logic            in_rd_w_src_csr;
    logic [XLEN-1:0] in_exu_result;
    logic [XLEN-1:0] in_lsu_r_data;
    logic [XLEN-1:0] in_csr_r_data;
    logic            in_csr_w_en;
    logic [11:0]     in_csr_addr;
    logic            in_inst_system_ebreak;

    modport master (
        output in_valid, in_pc, in_inst, in_rd, in_rd_w_en,
               in_rd_w_src_exu, in_rd_w_src_mem, in_rd_w_src_csr,
               in_exu_result, in_lsu_r_data, in_csr_r_data,
               in_csr_w_en, in_csr_addr, in_inst_system_ebreak,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_rd, in_rd_w_en,
               in_rd_w_src_exu, in_rd_w_src_mem, in_rd_w_src_csr,
               in_exu_result, in_lsu_r_data, in_csr_r_data,
               in_csr_w_en, in_csr_addr, in_inst_system_ebreak,
        output in_ready
    );
endinterface

// File: rtl/wbu.sv
// Write-back unit: selects rd data, owns the integer register file, issues CSR
// writes, records a commit trace and retire count, and halts after ebreak.
module wbu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    wbu_if.slave            mw,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wb_fwd_en,
    output logic [4:0]      wb_fwd_rd,
    output logic [XLEN-1:0] wb_fwd_data,
    output logic            csr_w_en,
    output logic [11:0]     csr_w_addr,
    output logic [XLEN-1:0] csr_w_data,
    output logic            commit_valid,
    output logic [31:0]     commit_pc,
    output logic [31:0]     commit_inst,
    output logic [63:0]     retire_cnt,
    output logic            halted,
    output logic [XLEN-1:0] halt_code
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];
    logic            commit_valid_q, commit_valid_d;
    logic [31:0]     commit_pc_q, commit_pc_d;
    logic [31:0]     commit_inst_q, commit_inst_d;
    logic [63:0]     retire_cnt_q, retire_cnt_d;
    logic [XLEN-1:0] halt_code_q, halt_code_d;

    logic            fire;
    logic            rd_we;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] a0_bypass;
    logic [4:0]      rs_addr [2];
    logic [XLEN-1:0] rs_data [2];

    assign fire        = mw.in_valid & (state_q == RUN);
    assign rd_we       = fire & mw.in_rd_w_en & (mw.in_rd != 5'd0);
    assign mw.in_ready = (state_q == RUN);

    // Source priority is mem > csr > exu; exu also covers "no source selected".
    always_comb begin
        wb_data = mw.in_exu_result;
        if (mw.in_rd_w_src_mem) begin
            wb_data = mw.in_lsu_r_data;
        end else if (mw.in_rd_w_src_csr) begin
            wb_data = mw.in_csr_r_data;
        end
    end

    assign wb_fwd_en   = rd_we;
    assign wb_fwd_rd   = mw.in_rd;
    assign wb_fwd_data = wb_data;

    assign csr_w_en   = fire & mw.in_csr_w_en;
    assign csr_w_addr = mw.in_csr_addr;
    assign csr_w_data = mw.in_exu_result;

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;
    assign rs1_data   = rs_data[0];
    assign rs2_data   = rs_data[1];

    // Read ports see the in-flight write in the same cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            always_comb begin
                rs_data[gi] = regs_q[rs_addr[gi]];
                if (rs_addr[gi] == 5'd0) begin
                    rs_data[gi] = '0;
                end else if (rd_we && (rs_addr[gi] == mw.in_rd)) begin
                    rs_data[gi] = wb_data;
                end
            end
        end
    endgenerate

    assign a0_bypass = (rd_we && (mw.in_rd == 5'd10)) ? wb_data : regs_q[10];

    always_comb begin
        state_d        = state_q;
        regs_d         = regs_q;
        commit_valid_d = 1'b0;
        commit_pc_d    = commit_pc_q;
        commit_inst_d  = commit_inst_q;
        retire_cnt_d   = retire_cnt_q;
        halt_code_d    = halt_code_q;
        if (rd_we) begin
            regs_d[mw.in_rd] = wb_data;
        end
        if (fire) begin
            commit_valid_d = 1'b1;
            commit_pc_d    = mw.in_pc;
            commit_inst_d  = mw.in_inst;
            retire_cnt_d   = retire_cnt_q + 64'd1;
        end
        case (state_q)
            RUN: begin
                if (fire && mw.in_inst_system_ebreak) begin
                    state_d     = HALT;
                    halt_code_d = a0_bypass;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_inst_q  <= '0;
            retire_cnt_q   <= '0;
            halt_code_q    <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_inst_q  <= commit_inst_d;
            retire_cnt_q   <= retire_cnt_d;
            halt_code_q    <= halt_code_d;
            regs_q         <= regs_d;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
    assign commit_inst  = commit_inst_q;
    assign retire_cnt   = retire_cnt_q;
    assign halted       = (state_q == HALT);
    assign halt_code    = halt_code_q;

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: a vector table for data selection, writes and CSR
// port, plus hand-written halt, reset-in-halt and counter-wrap sequences.
module tb_wbu;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_rd;
    logic [63:0] wb_fwd_data;
    logic        csr_w_en;
    logic [11:0] csr_w_addr;
    logic [63:0] csr_w_data;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_inst;
    logic [63:0] retire_cnt;
    logic        halted;
    logic [63:0] halt_code;

    int errors = 0;
    int checks = 0;

    wbu_if #(.XLEN(64)) mw ();

    wbu #(.XLEN(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .mw           (mw),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_fwd_en    (wb_fwd_en),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .csr_w_en     (csr_w_en),
        .csr_w_addr   (csr_w_addr),
        .csr_w_data   (csr_w_data),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .retire_cnt   (retire_cnt),
        .halted       (halted),
        .halt_code    (halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic        w_en;
        logic        src_exu;
        logic        src_mem;
        logic        src_csr;
        logic [63:0] exu;
        logic [63:0] lsu;
        logic [63:0] csr_r;
        logic        csr_w;
        logic [11:0] csr_addr;
        logic        exp_fwd_en;
        logic [63:0] exp_data;
        logic        exp_csr_w_en;
    } vec_t;

    vec_t vecs [7];
    logic [63:0] model [32];
    logic [63:0] exp_cnt;
    logic [63:0] exp_bypass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_payload();
        mw.in_valid              = 1'b0;
        mw.in_pc                 = '0;
        mw.in_inst               = '0;
        mw.in_rd                 = '0;
        mw.in_rd_w_en            = 1'b0;
        mw.in_rd_w_src_exu       = 1'b0;
        mw.in_rd_w_src_mem       = 1'b0;
        mw.in_rd_w_src_csr       = 1'b0;
        mw.in_exu_result         = '0;
        mw.in_lsu_r_data         = '0;
        mw.in_csr_r_data         = '0;
        mw.in_csr_w_en           = 1'b0;
        mw.in_csr_addr           = '0;
        mw.in_inst_system_ebreak = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // valid rd w src_exu src_mem src_csr exu lsu csr_r csr_w addr | fwd data csrw
        vecs[0] = '{1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 64'h1234,      64'h0,  64'h0,  1'b0, 12'h000, 1'b1, 64'h1234,      1'b0};
        vecs[1] = '{1'b1, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 64'hFFFF,      64'h0,  64'h0,  1'b0, 12'h000, 1'b0, 64'hFFFF,      1'b0};
        vecs[2] = '{1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 64'h8000_0000, 64'hAA, 64'hBB, 1'b1, 12'h305, 1'b1, 64'hAA,        1'b1};
        vecs[3] = '{1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 64'h11,        64'h22, 64'hBB, 1'b0, 12'h000, 1'b1, 64'hBB,        1'b0};
        vecs[4] = '{1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 64'h55,        64'h66, 64'h77, 1'b0, 12'h000, 1'b1, 64'h55,        1'b0};
        vecs[5] = '{1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 64'h99,        64'h0,  64'h0,  1'b1, 12'h300, 1'b0, 64'h99,        1'b0};
        vecs[6] = '{1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 64'h7,         64'h0,  64'h0,  1'b0, 12'h000, 1'b1, 64'h7,         1'b0};

        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_cnt  = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        idle_payload();

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_halted", {63'd0, halted}, 64'd0);
        chk("reset_retire", retire_cnt, 64'd0);
        chk("reset_commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, mw.in_ready}, 64'd1);
        chk("reset_halt_code", halt_code, 64'd0);

        for (int v = 0; v < 7; v++) begin
            mw.in_valid        = vecs[v].valid;
            mw.in_pc           = 32'h1000 + 32'(v * 4);
            mw.in_inst         = 32'h0000_0013 + 32'(v << 8);
            mw.in_rd           = vecs[v].rd;
            mw.in_rd_w_en      = vecs[v].w_en;
            mw.in_rd_w_src_exu = vecs[v].src_exu;
            mw.in_rd_w_src_mem = vecs[v].src_mem;
            mw.in_rd_w_src_csr = vecs[v].src_csr;
            mw.in_exu_result   = vecs[v].exu;
            mw.in_lsu_r_data   = vecs[v].lsu;
            mw.in_csr_r_data   = vecs[v].csr_r;
            mw.in_csr_w_en     = vecs[v].csr_w;
            mw.in_csr_addr     = vecs[v].csr_addr;
            rs1_addr           = vecs[v].rd;
            #1;
            if (vecs[v].rd == 5'd0)   exp_bypass = '0;
            else if (vecs[v].exp_fwd_en) exp_bypass = vecs[v].exp_data;
            else                      exp_bypass = model[vecs[v].rd];
            chk($sformatf("v%0d_fwd_en", v), {63'd0, wb_fwd_en}, {63'd0, vecs[v].exp_fwd_en});
            chk($sformatf("v%0d_fwd_data", v), wb_fwd_data, vecs[v].exp_data);
            chk($sformatf("v%0d_csr_w_en", v), {63'd0, csr_w_en}, {63'd0, vecs[v].exp_csr_w_en});
            if (vecs[v].exp_csr_w_en) begin
                chk($sformatf("v%0d_csr_w_addr", v), {52'd0, csr_w_addr}, {52'd0, vecs[v].csr_addr});
                chk($sformatf("v%0d_csr_w_data", v), csr_w_data, vecs[v].exu);
            end
            chk($sformatf("v%0d_rs1_bypass", v), rs1_data, exp_bypass);
            if (vecs[v].exp_fwd_en) model[vecs[v].rd] = vecs[v].exp_data;
            if (vecs[v].valid) exp_cnt = exp_cnt + 64'd1;

            step();
            idle_payload();
            rs2_addr = vecs[v].rd;
            #1;
            chk($sformatf("v%0d_commit_valid", v), {63'd0, commit_valid}, {63'd0, vecs[v].valid});
            if (vecs[v].valid) begin
                chk($sformatf("v%0d_commit_pc", v), {32'd0, commit_pc}, {32'd0, 32'h1000 + 32'(v * 4)});
            end
            chk($sformatf("v%0d_retire", v), retire_cnt, exp_cnt);
            chk($sformatf("v%0d_rs2_array", v), rs2_data, model[vecs[v].rd]);
            chk($sformatf("v%0d_csr_w_gone", v), {63'd0, csr_w_en}, 64'd0);
            $display("vec %0d: valid=%0b rd=%0d data=0x%0h retire=%0d", v, vecs[v].valid,
                     vecs[v].rd, wb_fwd_data, retire_cnt);
        end

        // ebreak with x10=7 already in the array
        mw.in_valid              = 1'b1;
        mw.in_pc                 = 32'h2000;
        mw.in_inst               = 32'h0010_0073;
        mw.in_inst_system_ebreak = 1'b1;
        step();
        idle_payload();
        exp_cnt = exp_cnt + 64'd1;
        chk("ebreak_halted", {63'd0, halted}, 64'd1);
        chk("ebreak_halt_code", halt_code, 64'h7);
        chk("ebreak_commit_valid", {63'd0, commit_valid}, 64'd1);
        chk("ebreak_commit_inst", {32'd0, commit_inst}, 64'h0010_0073);
        chk("ebreak_retire", retire_cnt, exp_cnt);
        chk("ebreak_in_ready", {63'd0, mw.in_ready}, 64'd0);
        $display("ebreak: halted=%0b halt_code=0x%0h retire=%0d", halted, halt_code, retire_cnt);

        // payloads offered while halted must have no effect
        mw.in_valid        = 1'b1;
        mw.in_rd           = 5'd12;
        mw.in_rd_w_en      = 1'b1;
        mw.in_rd_w_src_exu = 1'b1;
        mw.in_exu_result   = 64'hDEAD;
        mw.in_csr_w_en     = 1'b1;
        mw.in_csr_addr     = 12'h305;
        rs1_addr           = 5'd12;
        rs2_addr           = 5'd10;
        #1;
        chk("halt_fwd_en", {63'd0, wb_fwd_en}, 64'd0);
        chk("halt_csr_w_en", {63'd0, csr_w_en}, 64'd0);
        step();
        step();
        chk("halt_retire_frozen", retire_cnt, exp_cnt);
        chk("halt_commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("halt_no_write", rs1_data, 64'd0);
        chk("halt_read_a0", rs2_data, 64'h7);
        chk("halt_sticky", {63'd0, halted}, 64'd1);
        $display("halted: retire=%0d x12=0x%0h", retire_cnt, rs1_data);

        // reset during HALT with a live payload
        rst      = 1'b1;
        rs1_addr = 5'd5;
        step();
        rst = 1'b0;
        idle_payload();
        #1;
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_retire", retire_cnt, 64'd0);
        chk("rst_read_x5", rs1_data, 64'd0);
        chk("rst_read_a0", rs2_data, 64'd0);
        chk("rst_in_ready", {63'd0, mw.in_ready}, 64'd1);
        chk("rst_commit_pc", {32'd0, commit_pc}, 64'd0);
        chk("rst_halt_code", halt_code, 64'd0);
        $display("reset in halt: halted=%0b retire=%0d", halted, retire_cnt);

        // ebreak that writes a0 itself: halt_code takes the bypassed value
        mw.in_valid              = 1'b1;
        mw.in_rd                 = 5'd10;
        mw.in_rd_w_en            = 1'b1;
        mw.in_rd_w_src_mem       = 1'b1;
        mw.in_lsu_r_data         = 64'h42;
        mw.in_exu_result         = 64'h1;
        mw.in_inst_system_ebreak = 1'b1;
        step();
        idle_payload();
        chk("ebreak_wr_a0_code", halt_code, 64'h42);
        chk("ebreak_wr_a0_reg", rs2_data, 64'h42);
        chk("ebreak_wr_a0_retire", retire_cnt, 64'd1);
        $display("ebreak writing a0: halt_code=0x%0h", halt_code);

        rst = 1'b1;
        step();
        rst = 1'b0;

        // counter wrap: preload all-ones and look at the next-state value
        force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        mw.in_valid = 1'b1;
        #1;
        chk("wrap_next_on_fire", dut.retire_cnt_d, 64'd0);
        mw.in_valid = 1'b0;
        #1;
        chk("wrap_hold_no_fire", dut.retire_cnt_d, 64'hFFFF_FFFF_FFFF_FFFF);
        release dut.retire_cnt_q;
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("wrap check done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
